// File: rtl/lc3_mem_pkg.sv
// Shared types and MMIO register addresses for the LC-3 memory controller.
package lc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DISP,
        RESP
    } state_t;

    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;
    localparam logic [15:0] DSR  = 16'hFE04;
    localparam logic [15:0] DDR  = 16'hFE06;

endpackage

// File: rtl/mem_ctrl_mmio_regs.sv
// Keyboard/display device registers: KBSR/KBDR state, MMIO read mux and DDR output regs.
module mmio_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        kb_valid,
    input  logic [7:0]  kb_char,
    input  logic        disp_ready,
    input  logic [15:0] addr,
    input  logic        rd_en,
    output logic [15:0] rdata,
    input  logic        disp_load,
    input  logic [7:0]  disp_data,
    output logic        disp_valid,
    output logic [7:0]  disp_char
);

    logic       kb_full;
    logic [7:0] kbdr;

    // A new character takes priority over the clear from a KBDR read in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kb_full <= 1'b0;
            kbdr    <= 8'h00;
        end else if (kb_valid) begin
            kb_full <= 1'b1;
            kbdr    <= kb_char;
        end else if (rd_en && addr == KBDR) begin
            kb_full <= 1'b0;
        end
    end

    always_comb begin
        rdata = 16'h0000;
        case (addr)
            KBSR:    rdata = {kb_full, 15'b0};
            KBDR:    rdata = {8'h00, kbdr};
            DSR:     rdata = {disp_ready, 15'b0};
            default: rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_valid <= 1'b0;
            disp_char  <= 8'h00;
        end else begin
            disp_valid <= disp_load;
            if (disp_load) begin
                disp_char <= disp_data;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// LC-3 memory controller: one load/store per handshake to sync RAM or MMIO space.
// IDLE accept | ISSUE RAM strobe | WAIT RAM latency | DISP display stall | RESP completion
module mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int         RAM_LAT = 1,
    parameter logic [6:0] MMIO_HI = 7'h7F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_data,
    input  logic        kb_valid,
    input  logic [7:0]  kb_char,
    input  logic        disp_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_char
);

    localparam int CW = $clog2(RAM_LAT + 1);

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            cpu_mmio;
    logic            we_q;
    logic [7:0]      ddr_byte;
    logic [CW-1:0]   lat_cnt;
    logic            lat_done;
    logic            disp_load;
    logic            mmio_rd;
    logic [15:0]     mmio_rdata;

    assign cpu_ready  = (state == IDLE);
    assign cpu_rvalid = (state == RESP);
    assign accept     = cpu_req && cpu_ready;
    assign cpu_mmio   = (cpu_addr[15:9] == MMIO_HI);
    assign lat_done   = (lat_cnt == CW'(1));
    assign disp_load  = (state == DISP) && disp_ready;
    assign mmio_rd    = accept && cpu_mmio && !cpu_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!cpu_mmio) begin
                        state_nxt = ISSUE;
                    end else if (cpu_we && cpu_addr == DDR) begin
                        state_nxt = DISP;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            ISSUE:   state_nxt = we_q ? RESP : WAIT;
            WAIT:    if (lat_done) state_nxt = RESP;
            DISP:    if (disp_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM strobes are registered off the accept so they are high exactly during ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            ddr_byte  <= 8'h00;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 16'h0000;
            ram_wdata <= 16'h0000;
        end else begin
            ram_en <= accept && !cpu_mmio;
            ram_we <= accept && !cpu_mmio && cpu_we;
            if (accept) begin
                we_q     <= cpu_we;
                ddr_byte <= cpu_wdata[7:0];
                if (!cpu_mmio) begin
                    ram_addr  <= cpu_addr;
                    ram_wdata <= cpu_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (state == ISSUE) begin
            lat_cnt <= CW'(RAM_LAT);
        end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata <= 16'h0000;
        end else if (mmio_rd) begin
            cpu_rdata <= mmio_rdata;
        end else if (state == WAIT && lat_done) begin
            cpu_rdata <= ram_data;
        end
    end

    mmio_regs u_mmio (
        .clk        (clk),
        .rst        (rst),
        .kb_valid   (kb_valid),
        .kb_char    (kb_char),
        .disp_ready (disp_ready),
        .addr       (cpu_addr),
        .rd_en      (mmio_rd),
        .rdata      (mmio_rdata),
        .disp_load  (disp_load),
        .disp_data  (ddr_byte),
        .disp_valid (disp_valid),
        .disp_char  (disp_char)
    );

endmodule
